// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [7:0] VAL_PENNY   = 8'd1;
  localparam logic [7:0] VAL_NICKEL  = 8'd5;
  localparam logic [7:0] VAL_DIME    = 8'd10;
  localparam logic [7:0] VAL_QUARTER = 8'd25;

  localparam int PRICE_APPLE_DEF  = 75;
  localparam int PRICE_BANANA_DEF = 20;
  localparam int PRICE_CARROT_DEF = 30;
  localparam int PRICE_DATE_DEF   = 40;
  localparam int MAX_CREDIT_DEF   = 200;

  localparam int COIN_PENNY   = 0;
  localparam int COIN_NICKEL  = 1;
  localparam int COIN_DIME    = 2;
  localparam int COIN_QUARTER = 3;

  localparam int PROD_APPLE  = 0;
  localparam int PROD_BANANA = 1;
  localparam int PROD_CARROT = 2;
  localparam int PROD_DATE   = 3;

  // Highest-value inserted coin wins; other simultaneous bits are dropped.
  function automatic logic [7:0] coin_value(input logic [3:0] coin);
    if (coin[COIN_QUARTER])     return VAL_QUARTER;
    else if (coin[COIN_DIME])   return VAL_DIME;
    else if (coin[COIN_NICKEL]) return VAL_NICKEL;
    else if (coin[COIN_PENNY])  return VAL_PENNY;
    else                        return 8'd0;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Front-panel inputs and actuator/status outputs of the vending controller.
interface vend_if;
  logic [3:0] coin;
  logic [3:0] req;
  logic       cancel;
  logic [7:0] credit;
  logic [3:0] dispense;
  logic [3:0] change;
  logic       coin_reject;
  logic       deny;
  logic       busy;

  modport master (
    output coin, req, cancel,
    input  credit, dispense, change, coin_reject, deny, busy
  );

  modport slave (
    input  coin, req, cancel,
    output credit, dispense, change, coin_reject, deny, busy
  );
endinterface

// File: rtl/vend_change_sel.sv
// Picks the largest coin not exceeding the remaining credit (greedy change).
import vend_pkg::*;

module vend_change_sel (
  input  logic [7:0] credit,
  output logic [3:0] sel,
  output logic [7:0] value
);

  always_comb begin
    sel   = '0;
    value = '0;
    if (credit >= VAL_QUARTER) begin
      sel[COIN_QUARTER] = 1'b1;
      value             = VAL_QUARTER;
    end else if (credit >= VAL_DIME) begin
      sel[COIN_DIME] = 1'b1;
      value          = VAL_DIME;
    end else if (credit >= VAL_NICKEL) begin
      sel[COIN_NICKEL] = 1'b1;
      value            = VAL_NICKEL;
    end else if (credit >= VAL_PENNY) begin
      sel[COIN_PENNY] = 1'b1;
      value           = VAL_PENNY;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending credit controller: accepts coins, grants products, then pays out
// the remaining credit greedily one coin per cycle.
import vend_pkg::*;

module vend_controller #(
  parameter int PRICE_APPLE  = PRICE_APPLE_DEF,
  parameter int PRICE_BANANA = PRICE_BANANA_DEF,
  parameter int PRICE_CARROT = PRICE_CARROT_DEF,
  parameter int PRICE_DATE   = PRICE_DATE_DEF,
  parameter int MAX_CREDIT   = MAX_CREDIT_DEF
) (
  input  logic   clk,
  input  logic   reset,
  vend_if.slave  bus
);

  state_t     state, state_n;
  logic [7:0] credit, credit_n;
  logic [3:0] dispense, dispense_n;
  logic [3:0] change, change_n;
  logic       coin_reject, coin_reject_n;
  logic       deny, deny_n;

  logic [3:0] chg_sel;
  logic [7:0] chg_val;
  logic [7:0] coin_val;
  logic [8:0] coin_sum;
  logic [3:0] req_onehot;
  logic [7:0] price;

  vend_change_sel u_change_sel (
    .credit (credit),
    .sel    (chg_sel),
    .value  (chg_val)
  );

  assign coin_val = coin_value(bus.coin);
  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

  // Lowest request bit wins; its price is looked up alongside.
  always_comb begin
    req_onehot = '0;
    price      = '0;
    if (bus.req[PROD_APPLE]) begin
      req_onehot[PROD_APPLE] = 1'b1;
      price                  = 8'(PRICE_APPLE);
    end else if (bus.req[PROD_BANANA]) begin
      req_onehot[PROD_BANANA] = 1'b1;
      price                   = 8'(PRICE_BANANA);
    end else if (bus.req[PROD_CARROT]) begin
      req_onehot[PROD_CARROT] = 1'b1;
      price                   = 8'(PRICE_CARROT);
    end else if (bus.req[PROD_DATE]) begin
      req_onehot[PROD_DATE] = 1'b1;
      price                 = 8'(PRICE_DATE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      dispense    <= '0;
      change      <= '0;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      dispense    <= dispense_n;
      change      <= change_n;
      coin_reject <= coin_reject_n;
      deny        <= deny_n;
    end
  end

  always_comb begin
    state_n       = state;
    credit_n      = credit;
    dispense_n    = '0;
    change_n      = '0;
    coin_reject_n = 1'b0;
    deny_n        = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.coin) begin
          if (coin_sum <= 9'(MAX_CREDIT)) credit_n = coin_sum[7:0];
          else                            coin_reject_n = 1'b1;
        end else if (|bus.req) begin
          if (credit >= price) begin
            credit_n   = credit - price;
            dispense_n = req_onehot;
            state_n    = VEND;
          end else begin
            deny_n = 1'b1;
          end
        end else if (bus.cancel && (credit != 8'd0)) begin
          state_n = CHANGE;
        end
      end
      VEND: begin
        coin_reject_n = |bus.coin;
        state_n       = (credit != 8'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_n = |bus.coin;
        change_n      = chg_sel;
        credit_n      = credit - chg_val;
        if (credit <= chg_val) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.credit      = credit;
  assign bus.dispense    = dispense;
  assign bus.change      = change;
  assign bus.coin_reject = coin_reject;
  assign bus.deny        = deny;
  assign bus.busy        = (state != IDLE);

endmodule
